// File: rtl/mem_debug_dump_ctrl.sv
// Walks the data memory while the pipeline is halted and streams every word, MSB byte first,
// to the debug UART over a valid/ready byte handshake.
module mem_debug_dump_ctrl #(
    parameter int unsigned NB_DATA     = 32,
    parameter int unsigned NB_ADDR     = 7,
    parameter int unsigned N_WORDS     = 128,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               pipeline_halted_i,
    input  logic [NB_DATA-1:0] data_mem_i,
    input  logic               tx_ready_i,
    output logic [NB_ADDR-1:0] addr_mem_debug_o,
    output logic               select_debug_o,
    output logic               mem_en_o,
    output logic [7:0]         tx_data_o,
    output logic               tx_valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               abort_o
);

    localparam int unsigned NB_BYTES = NB_DATA / 8;
    localparam int unsigned BW       = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam int unsigned LW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    // One extra bit so N_WORDS = 2^NB_ADDR reaches its last index without wrapping.
    localparam int unsigned KW       = NB_ADDR + 1;

    localparam logic [KW-1:0] LAST_WORD = KW'(N_WORDS - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NB_BYTES - 1);
    localparam logic [LW-1:0] LAST_LAT  = LW'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {StIdle, StAddr, StWait, StLatch, StSend, StDone} state_e;

    state_e             state_q;
    logic [KW-1:0]      word_q;
    logic [BW-1:0]      byte_q;
    logic [LW-1:0]      lat_q;
    logic [NB_DATA-1:0] shift_q;
    logic [KW-1:0]      word_inc;

    assign word_inc  = word_q + KW'(1);
    assign tx_data_o = shift_q[NB_DATA-1 -: 8];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q          <= StIdle;
            word_q           <= '0;
            byte_q           <= '0;
            lat_q            <= '0;
            shift_q          <= '0;
            addr_mem_debug_o <= '0;
            select_debug_o   <= 1'b0;
            mem_en_o         <= 1'b0;
            tx_valid_o       <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            abort_o          <= 1'b0;
        end else begin
            done_o  <= 1'b0;
            abort_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i && pipeline_halted_i) begin
                        state_q          <= StAddr;
                        word_q           <= '0;
                        addr_mem_debug_o <= '0;
                        select_debug_o   <= 1'b1;
                        mem_en_o         <= 1'b1;
                        busy_o           <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    if (!pipeline_halted_i) begin
                        // Pipeline resumed under us: drop the memory stage immediately.
                        state_q          <= StIdle;
                        abort_o          <= 1'b1;
                        shift_q          <= '0;
                        addr_mem_debug_o <= '0;
                        select_debug_o   <= 1'b0;
                        mem_en_o         <= 1'b0;
                        tx_valid_o       <= 1'b0;
                        busy_o           <= 1'b0;
                    end else begin
                        unique case (state_q)
                            StAddr: begin
                                state_q <= StWait;
                                lat_q   <= '0;
                            end
                            StWait: begin
                                if (lat_q == LAST_LAT) begin
                                    state_q  <= StLatch;
                                    mem_en_o <= 1'b0;
                                end else begin
                                    lat_q <= lat_q + LW'(1);
                                end
                            end
                            StLatch: begin
                                state_q    <= StSend;
                                shift_q    <= data_mem_i;
                                byte_q     <= '0;
                                tx_valid_o <= 1'b1;
                            end
                            StSend: begin
                                if (tx_ready_i) begin
                                    shift_q <= shift_q << 8;
                                    if (byte_q == LAST_BYTE) begin
                                        tx_valid_o <= 1'b0;
                                        if (word_q == LAST_WORD) begin
                                            state_q          <= StDone;
                                            done_o           <= 1'b1;
                                            addr_mem_debug_o <= '0;
                                            select_debug_o   <= 1'b0;
                                            busy_o           <= 1'b0;
                                        end else begin
                                            state_q          <= StAddr;
                                            word_q           <= word_inc;
                                            addr_mem_debug_o <= word_inc[NB_ADDR-1:0];
                                            mem_en_o         <= 1'b1;
                                        end
                                    end else begin
                                        byte_q <= byte_q + BW'(1);
                                    end
                                end
                            end
                            default: begin
                                state_q <= StIdle;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_debug_dump_ctrl.sv
// Directed bench for mem_debug_dump_ctrl: a 4-word instance for handshake, abort and reset
// scenarios, and a default 128-word instance for the full-range walk.
module tb_mem_debug_dump_ctrl;

    logic       clk;
    logic       rst;
    logic       start, halted, ready;
    logic [6:0] addr;
    logic       select, mem_en, tx_valid, busy, done, abort;
    logic [7:0] tx_data;
    logic [31:0] rdata_s;

    logic       start6, halted6, ready6;
    logic [6:0] addr6;
    logic       select6, mem_en6, tx_valid6, busy6, done6, abort6;
    logic [7:0] tx_data6;
    logic [31:0] rdata_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] small_word(input logic [6:0] a);
        case (a)
            7'd0:    return 32'h11223344;
            7'd1:    return 32'hAABBCCDD;
            7'd2:    return 32'h00000000;
            7'd3:    return 32'hFFFFFFFF;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    function automatic logic [31:0] big_word(input logic [6:0] a);
        logic [7:0] b;
        b = {1'b0, a};
        return {b, b ^ 8'h5A, b + 8'd1, ~b};
    endfunction

    always_ff @(posedge clk) if (mem_en) rdata_s <= small_word(addr);
    always_ff @(posedge clk) if (mem_en6) rdata_b <= big_word(addr6);

    mem_debug_dump_ctrl #(
        .NB_DATA(32), .NB_ADDR(7), .N_WORDS(4), .MEM_LATENCY(1)
    ) dut_s (
        .clock_i(clk), .reset_i(rst), .start_i(start), .pipeline_halted_i(halted),
        .data_mem_i(rdata_s), .tx_ready_i(ready), .addr_mem_debug_o(addr),
        .select_debug_o(select), .mem_en_o(mem_en), .tx_data_o(tx_data),
        .tx_valid_o(tx_valid), .busy_o(busy), .done_o(done), .abort_o(abort)
    );

    mem_debug_dump_ctrl dut_b (
        .clock_i(clk), .reset_i(rst), .start_i(start6), .pipeline_halted_i(halted6),
        .data_mem_i(rdata_b), .tx_ready_i(ready6), .addr_mem_debug_o(addr6),
        .select_debug_o(select6), .mem_en_o(mem_en6), .tx_data_o(tx_data6),
        .tx_valid_o(tx_valid6), .busy_o(busy6), .done_o(done6), .abort_o(abort6)
    );

    logic [7:0] exp_bytes [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                                   8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    int n_vec = 0, n_err = 0;
    int cyc = 0;
    logic [7:0] got_q [$];
    logic [6:0] got_a [$];
    int done_cnt, abort_cnt, done_cyc, first_valid_cyc, stall_err, done_bad, start_cyc;
    logic pv = 1'b0, pr = 1'b0, ph = 1'b0, prst = 1'b1;
    logic [7:0] pd = 8'h00;
    int n6, err6, max6, done6_cnt, done6_cyc, start6_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task sample();
        logic [31:0] w;
        if (tx_valid && ready) begin
            got_q.push_back(tx_data);
            got_a.push_back(addr);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (select || busy) done_bad++;
        end
        if (abort) abort_cnt++;
        if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (pv && !pr && ph && !prst && !(tx_valid && tx_data == pd)) stall_err++;
        pv = tx_valid; pr = ready; ph = halted; prst = rst; pd = tx_data;

        if (tx_valid6 && ready6) begin
            w = big_word(7'(n6 / 4));
            if (tx_data6 !== w[31 - 8 * (n6 % 4) -: 8] || addr6 !== 7'(n6 / 4)) err6++;
            n6++;
        end
        if (int'(addr6) > max6) max6 = int'(addr6);
        if (done6) begin
            done6_cnt++;
            done6_cyc = cyc;
        end
    endtask

    task step();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task clear();
        got_q.delete();
        got_a.delete();
        done_cnt = 0; abort_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
        stall_err = 0; done_bad = 0;
    endtask

    task pulse_start();
        start = 1'b1;
        start_cyc = cyc + 1;
        step();
        start = 1'b0;
    endtask

    task run_until_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, (done_cnt != 0), 1);
    endtask

    task check_dump(input string tag);
        int bad_addr;
        check({tag, "_nbytes"}, got_q.size(), 16);
        bad_addr = 0;
        for (int i = 0; i < got_q.size() && i < 16; i++) begin
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_bytes[i]);
            if (got_a[i] !== 7'(i / 4)) bad_addr++;
        end
        check({tag, "_addr_per_word"}, bad_addr, 0);
    endtask

    task check_idle_outputs(input string tag);
        check({tag, "_select"}, select, 0);
        check({tag, "_mem_en"}, mem_en, 0);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_abort"}, abort, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_tx_data"}, tx_data, 0);
    endtask

    initial begin
        int n, stall, stall_events;
        rst = 1'b1; start = 1'b0; halted = 1'b0; ready = 1'b0;
        start6 = 1'b0; halted6 = 1'b1; ready6 = 1'b1;
        n6 = 0; err6 = 0; max6 = 0; done6_cnt = 0; done6_cyc = -1; start6_cyc = 0;
        clear();
        step();
        step();
        check_idle_outputs("reset");
        rst = 1'b0;
        step();

        // 1: plain dump, ready always high
        halted = 1'b1; ready = 1'b1;
        clear();
        pulse_start();
        run_until_done("t1", 60);
        step();
        step();
        check_dump("t1");
        check("t1_first_valid_lat", first_valid_cyc - start_cyc, 3);
        check("t1_done_lat", done_cyc - start_cyc, 28);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_done_cycle_select_busy", done_bad, 0);

        // 2: ready low for 5 cycles before every odd-indexed byte
        clear();
        stall = 0; stall_events = 0; n = 0;
        pulse_start();
        while (done_cnt == 0 && n < 200) begin
            step();
            n++;
            if (stall > 0) begin
                stall--;
                if (stall == 0) ready = 1'b1;
            end else if (tx_valid && (got_q.size() % 2 == 1)) begin
                ready = 1'b0;
                stall = 5;
                stall_events++;
            end
        end
        ready = 1'b1;
        check("t2_timeout", (done_cnt != 0), 1);
        step();
        check_dump("t2");
        check("t2_stall_events", stall_events, 8);
        check("t2_stall_stability", stall_err, 0);
        check("t2_done_pulses", done_cnt, 1);

        // 3: start while not halted, then a second start during an active dump
        halted = 1'b0;
        clear();
        pulse_start();
        repeat (5) step();
        check("t3_busy_not_halted", busy, 0);
        check("t3_no_valid_not_halted", first_valid_cyc, -1);
        halted = 1'b1;
        clear();
        pulse_start();
        repeat (10) step();
        pulse_start();
        run_until_done("t3", 60);
        repeat (10) step();
        check("t3_nbytes_total", got_q.size(), 16);
        check("t3_done_pulses", done_cnt, 1);

        // 4: abort while byte 1 of word 2 is handed over
        clear();
        pulse_start();
        n = 0;
        while (got_q.size() < 9 && n < 100) begin
            step();
            n++;
        end
        check("t4_reach_w2b1", got_q.size(), 9);
        halted = 1'b0;
        step();
        check("t4_abort_pulse", abort, 1);
        check("t4_select_low", select, 0);
        check("t4_valid_low", tx_valid, 0);
        check("t4_busy_low", busy, 0);
        step();
        check("t4_abort_one_cycle", abort, 0);
        check("t4_abort_count", abort_cnt, 1);
        check("t4_no_done", done_cnt, 0);
        check("t4_bytes_incl_last", got_q.size(), 10);
        halted = 1'b1;
        clear();
        pulse_start();
        run_until_done("t4r", 60);
        step();
        check_dump("t4r");

        // 5: reset during WAIT of word 1
        clear();
        pulse_start();
        repeat (8) step();
        check("t5_addr_word1", addr, 1);
        check("t5_select_word1", select, 1);
        rst = 1'b1;
        step();
        check_idle_outputs("t5_after_reset");
        rst = 1'b0;
        step();
        step();
        check("t5_no_done", done_cnt, 0);
        check("t5_no_abort", abort_cnt, 0);
        clear();
        pulse_start();
        run_until_done("t5r", 60);
        step();
        check_dump("t5r");
        check("t5r_done_lat", done_cyc - start_cyc, 28);

        // 6: default 128-word instance
        start6 = 1'b1;
        start6_cyc = cyc + 1;
        step();
        start6 = 1'b0;
        n = 0;
        while (done6_cnt == 0 && n < 1000) begin
            step();
            n++;
        end
        step();
        check("t6_timeout", (done6_cnt != 0), 1);
        check("t6_nbytes", n6, 512);
        check("t6_max_addr", max6, 127);
        check("t6_byte_or_addr_errors", err6, 0);
        check("t6_done_lat", done6_cyc - start6_cyc, 896);
        check("t6_done_pulses", done6_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
